ber_meter: RTL and testbench

Parametrised multi-channel bit-error-rate meter for the QPSK baseband link. It succeeds the fixed two-channel BER checker with a fixed delay. For each of NCH channels it searches for the system delay between the transmit PRBS reference and the slicer decision, and locks to it. Once locked it accumulates bit and error counts in saturating counters, and it detects loss of lock. It sits after the slicers in the receive chain and feeds the LED/status logic and the counter readout.

---
 rtl/ber_meter.sv | 113 +++++++++++
 tb/tb_ber_meter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ber_meter.sv
// Multi-channel BER meter: per-channel delay search against a PRBS reference,
// lock detection, saturating bit/error counters and loss-of-lock monitoring.
module ber_meter #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DLY_W  = 9,
  parameter int unsigned WIN    = 128,
  parameter int unsigned ERR_TH = 0,
  parameter int unsigned LOL_TH = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [NCH-1:0]       i_prbs,
  input  logic [NCH-1:0]       i_slicer,
  input  logic                 i_clear,
  output logic [NCH-1:0]       o_locked,
  output logic [NCH-1:0]       o_ber,
  output logic [NCH*DLY_W-1:0] o_delay,
  output logic [NCH*CNT_W-1:0] o_bit_cnt,
  output logic [NCH*CNT_W-1:0] o_err_cnt
);

  localparam int unsigned DEPTH = 1 << DLY_W;
  localparam int unsigned WC_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned WE_W  = $clog2(WIN + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  logic w_strobe;
  assign w_strobe = i_enable & i_valid;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_t            r_state;
    logic [DEPTH-2:0]  r_line;
    logic [DEPTH-1:0]  w_taps;
    logic [DLY_W-1:0]  r_delay;
    logic [WC_W-1:0]   r_wc;
    logic [WE_W-1:0]   r_we;
    logic [WE_W-1:0]   w_we_next;
    logic [CNT_W-1:0]  r_bits;
    logic [CNT_W-1:0]  r_errs;
    logic              r_ber;
    logic              w_mis;
    logic              w_last;

    // Tap 0 is the live reference bit; tap d>0 comes from the stored history.
    assign w_taps    = {r_line, i_prbs[k]};
    assign w_mis     = i_slicer[k] ^ w_taps[r_delay];
    assign w_we_next = r_we + WE_W'(w_mis);
    assign w_last    = (r_wc == WC_W'(WIN - 1));

    always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
        r_state <= SEARCH;
        r_line  <= '0;
        r_delay <= '0;
        r_wc    <= '0;
        r_we    <= '0;
        r_bits  <= '0;
        r_errs  <= '0;
        r_ber   <= 1'b0;
      end else begin
        if (w_strobe) begin
          r_line <= {r_line[DEPTH-3:0], i_prbs[k]};
          r_ber  <= w_mis;
          if (w_last) begin
            r_wc <= '0;
            r_we <= '0;
          end else begin
            r_wc <= r_wc + 1'b1;
            r_we <= w_we_next;
          end
          case (r_state)
            SEARCH: begin
              if (w_last) begin
                if (32'(w_we_next) <= ERR_TH) begin
                  r_state <= LOCKED;
                  r_bits  <= '0;
                  r_errs  <= '0;
                end else begin
                  r_delay <= r_delay + 1'b1;
                end
              end
            end
            LOCKED: begin
              if (r_bits != '1) begin
                r_bits <= r_bits + 1'b1;
                if (w_mis && (r_errs != '1))
                  r_errs <= r_errs + 1'b1;
              end
              // Delay is kept so the search retests the last good tap first.
              if (w_last && (32'(w_we_next) > LOL_TH))
                r_state <= SEARCH;
            end
          endcase
        end
        if (i_clear) begin
          r_bits <= '0;
          r_errs <= '0;
        end
      end
    end

    assign o_locked[k]                  = (r_state == LOCKED);
    assign o_ber[k]                     = r_ber;
    assign o_delay[k*DLY_W +: DLY_W]    = r_delay;
    assign o_bit_cnt[k*CNT_W +: CNT_W]  = r_bits;
    assign o_err_cnt[k*CNT_W +: CNT_W]  = r_errs;
  end

endmodule

// File: tb/tb_ber_meter.sv
// Bench for ber_meter: two instances (32-bit and 8-bit counters) share stimulus
// and are checked every cycle against a history-array reference model.
module tb_ber_meter;

  localparam int unsigned NCH = 2, DLY_W = 9, WIN = 128, ERR_TH = 0, LOL_TH = 32;
  localparam int unsigned HMAX = 65536;

  logic clock, rst, en, val, clr;
  logic [1:0] prbs, slc;
  logic [1:0]  a_locked, a_ber, b_locked, b_ber;
  logic [17:0] a_delay, b_delay;
  logic [63:0] a_bits, a_errs;
  logic [15:0] b_bits, b_errs;

  ber_meter #(.NCH(NCH), .DLY_W(DLY_W), .WIN(WIN), .ERR_TH(ERR_TH), .LOL_TH(LOL_TH), .CNT_W(32)) u_a (
    .clock(clock), .i_reset(rst), .i_enable(en), .i_valid(val), .i_prbs(prbs), .i_slicer(slc),
    .i_clear(clr), .o_locked(a_locked), .o_ber(a_ber), .o_delay(a_delay),
    .o_bit_cnt(a_bits), .o_err_cnt(a_errs));

  ber_meter #(.NCH(NCH), .DLY_W(DLY_W), .WIN(WIN), .ERR_TH(ERR_TH), .LOL_TH(LOL_TH), .CNT_W(8)) u_b (
    .clock(clock), .i_reset(rst), .i_enable(en), .i_valid(val), .i_prbs(prbs), .i_slicer(slc),
    .i_clear(clr), .o_locked(b_locked), .o_ber(b_ber), .o_delay(b_delay),
    .o_bit_cnt(b_bits), .o_err_cnt(b_errs));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tests = 0, fails = 0;
  bit started = 0;

  // Model: channels 0,1 -> instance A, 2,3 -> instance B (same input channel m%2)
  bit               hist [2][HMAX];
  int unsigned      n;
  bit               mlock [4];
  bit               mber  [4];
  int unsigned      mdly  [4];
  int unsigned      mwc   [4];
  int unsigned      mwe   [4];
  longint unsigned  mbits [4];
  longint unsigned  merrs [4];
  logic [8:0]       lfsr [2];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int m = 0; m < 4; m++) begin
      mlock[m] = 0; mber[m] = 0; mdly[m] = 0; mwc[m] = 0; mwe[m] = 0;
      mbits[m] = 0; merrs[m] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit c_clr, input bit [1:0] sl);
    longint unsigned mx;
    bit tap, mis;
    int c;
    for (int m = 0; m < 4; m++) begin
      c  = m % 2;
      mx = (m < 2) ? 64'hFFFF_FFFF : 64'd255;
      if (s) begin
        tap = (n >= mdly[m]) ? hist[c][n - mdly[m]] : 1'b0;
        mis = sl[c] ^ tap;
        mber[m] = mis;
        mwe[m] += mis;
        mwc[m] += 1;
        if (mlock[m] && mbits[m] < mx) begin
          mbits[m]++;
          if (mis && merrs[m] < mx) merrs[m]++;
        end
        if (mwc[m] == WIN) begin
          if (!mlock[m]) begin
            if (mwe[m] <= ERR_TH) begin
              mlock[m] = 1; mbits[m] = 0; merrs[m] = 0;
            end else begin
              mdly[m] = (mdly[m] + 1) % (1 << DLY_W);
            end
          end else if (mwe[m] > LOL_TH) begin
            mlock[m] = 0;
          end
          mwc[m] = 0; mwe[m] = 0;
        end
      end
      if (c_clr) begin mbits[m] = 0; merrs[m] = 0; end
    end
    if (s) n++;
  endtask

  // One cycle: drive at negedge, advance model, return at posedge+3.
  task automatic step(input bit r, input bit e, input bit v, input bit c, input bit inv0, input bit flip0);
    bit s;
    bit [1:0] p, sl;
    @(negedge clock);
    s = e & v & ~r;
    p = 2'($urandom);
    sl = 2'($urandom);
    if (s && n < HMAX) begin
      for (int k = 0; k < 2; k++) begin
        p[k] = lfsr[k][8];
        lfsr[k] = {lfsr[k][7:0], lfsr[k][8] ^ lfsr[k][4]};
        hist[k][n] = p[k];
      end
      sl[0] = ((n >= 5) ? hist[0][n-5] : 1'b0) ^ inv0 ^ flip0;
      sl[1] = (n >= 37) ? hist[1][n-37] : 1'b0;
    end
    rst = r; en = e; val = v; clr = c; prbs = p; slc = sl;
    if (r) model_reset();
    else model_step(s, c, sl);
    @(posedge clock);
    #3;
  endtask

  always @(posedge clock) begin
    #2;
    if (started) begin
      for (int m = 0; m < 4; m++) begin
        int c;
        c = m % 2;
        if (m < 2) begin
          chk($sformatf("locked ch%0d", m), a_locked[c], mlock[m]);
          chk($sformatf("ber ch%0d", m), a_ber[c], mber[m]);
          chk($sformatf("delay ch%0d", m), a_delay[c*9 +: 9], mdly[m]);
          chk($sformatf("bits ch%0d", m), a_bits[c*32 +: 32], mbits[m]);
          chk($sformatf("errs ch%0d", m), a_errs[c*32 +: 32], merrs[m]);
        end else begin
          chk($sformatf("locked ch%0d", m), b_locked[c], mlock[m]);
          chk($sformatf("ber ch%0d", m), b_ber[c], mber[m]);
          chk($sformatf("delay ch%0d", m), b_delay[c*9 +: 9], mdly[m]);
          chk($sformatf("bits ch%0d", m), b_bits[c*8 +: 8], mbits[m]);
          chk($sformatf("errs ch%0d", m), b_errs[c*8 +: 8], merrs[m]);
        end
      end
    end
  end

  initial begin
    int unsigned lock0, lock1, cyc, j, cnt;
    bit got0, got1, frozen;
    lfsr[0] = 9'h1FF; lfsr[1] = 9'h0A5;
    rst = 1; en = 0; val = 0; clr = 0; prbs = 0; slc = 0;
    model_reset();
    started = 1;

    for (int i = 0; i < 3; i++) step(1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    chk("reset locked", {a_locked, b_locked}, 0);
    chk("reset delay", a_delay, 0);
    chk("reset counts", a_bits | a_errs, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    chk("idle after reset", {a_locked, a_ber, a_delay}, 0);

    // Acquisition, with a 50-cycle enable drop mid-search
    lock0 = 0; lock1 = 0; got0 = 0; got1 = 0; frozen = 0;
    for (cyc = 0; cyc < 24000 && !(got0 && got1); cyc++) begin
      if (!frozen && n == 300) begin
        frozen = 1;
        chk("delay before freeze", a_delay[8:0], 2);
        for (int i = 0; i < 50; i++) step(0, 0, (i % 4) == 0, 0, 0, 0);
        chk("delay after freeze", a_delay[8:0], 2);
      end
      step(0, 1, (cyc % 4) == 0, 0, 0, 0);
      if (!got0 && a_locked[0]) begin got0 = 1; lock0 = n; end
      if (!got1 && a_locked[1]) begin got1 = 1; lock1 = n; end
    end
    chk("ch0 lock strobes", lock0, 768);
    chk("ch0 lock delay", a_delay[8:0], 5);
    chk("ch1 lock strobes", lock1, 4864);
    chk("ch1 lock delay", a_delay[17:9], 37);

    // Error counting: every 100th ch0 bit inverted, random strobe gaps
    step(0, 0, 0, 1, 0, 0);
    j = 0;
    for (cyc = 0; cyc < 40000 && j < 10000; cyc++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      step(0, 1, v, 0, 0, v && (j % 100 == 99));
      if (v) j++;
    end
    chk("ch0 bit count", a_bits[31:0], 10000);
    chk("ch0 err count", a_errs[31:0], 100);
    chk("ch1 err count", a_errs[63:32], 0);
    chk("8b ch0 bit saturate", b_bits[7:0], 255);
    chk("8b ch0 err count", b_errs[7:0], 2);

    // Clear coincident with a strobe wins; counting restarts at 1
    step(0, 1, 1, 1, 0, 0);
    chk("8b clear", b_bits[7:0], 0);
    chk("32b clear", a_bits[31:0], 0);
    step(0, 1, 1, 0, 0, 0);
    chk("8b restart", b_bits[7:0], 1);

    // Loss of lock: align to a monitor window start, then invert ch0
    for (int i = 0; i < 200 && mwc[0] != 0; i++) step(0, 1, 1, 0, 0, 0);
    cnt = 0;
    while (a_locked[0] && cnt < 300) begin
      step(0, 1, 1, 0, 1, 0);
      cnt++;
    end
    chk("lol strobes", cnt, 128);
    chk("lol delay kept", a_delay[8:0], 5);
    chk("ch1 still locked", a_locked[1], 1);
    for (int i = 0; i < 128; i++) step(0, 1, 1, 0, 1, 0);
    chk("search stepped", a_delay[8:0], 6);
    chk("ch1 locked after", a_locked[1], 1);

    // Random tail
    for (int i = 0; i < 400; i++)
      step(0, $urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 31) == 0,
           1'($urandom), $urandom_range(0, 7) == 0);

    started = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
